// File: rtl/uart_autobaud_if.sv
// uart_autobaud_if
//   Signal bundle between the auto-baud detector and its user (the UART
//   receiver/transmitter control logic).
//
//   Handshake: `start` is a one-shot arm request that the detector only
//   samples while `busy` is low; requests seen while `busy` is high are
//   dropped. Each accepted request ends in exactly one single-cycle pulse on
//   either `done` (`bit_period`/`half_period` valid and updated in that same
//   cycle) or `error` (previous period kept), and `busy` is low in that
//   cycle. There is no backpressure: the user must take the pulse when it
//   appears.
//
//   Signals:
//     start       arm request (master -> slave)
//     rx          raw asynchronous serial line, idle high (master -> slave)
//     busy        measurement in progress (slave -> master)
//     done        one-cycle success pulse (slave -> master)
//     error       one-cycle rejection pulse (slave -> master)
//     bit_period  measured cycles per bit (slave -> master)
//     half_period bit_period >> 1 (slave -> master)
//     state_dbg   current FSM state encoding, for checkers (slave -> master)
`timescale 1ns/1ps

interface uart_autobaud_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 rx;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [CNT_WIDTH-1:0] bit_period;
    logic [CNT_WIDTH-1:0] half_period;
    logic [2:0]           state_dbg;

    modport master (
        output start,
        output rx,
        input  busy,
        input  done,
        input  error,
        input  bit_period,
        input  half_period,
        input  state_dbg
    );

    modport slave (
        input  start,
        input  rx,
        output busy,
        output done,
        output error,
        output bit_period,
        output half_period,
        output state_dbg
    );
endinterface

// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Measures the bit period of an incoming 0x55 sync character on an
//   asynchronous rx line. The five falling edges of 0x55 span exactly eight
//   bit times; the span is timed in system clocks and divided by eight with
//   rounding. Each edge-to-edge interval is also checked against the first
//   one so that a garbled or non-0x55 character is rejected.
//
//   Ports:
//     clock  system clock, all logic on its rising edge
//     reset  synchronous active-high reset
//     bus    uart_autobaud_if.slave: start, rx in; busy, done, error,
//            bit_period, half_period, state_dbg out
//
//   State encoding (visible on state_dbg):
//     0 IDLE, 1 WAIT_HIGH, 2 WAIT_FALL, 3 MEASURE, 4 CHECK, 5 FAIL
`timescale 1ns/1ps

module uart_autobaud #(
    parameter int CLOCK_INPUT = 50_000_000,
    parameter int CNT_WIDTH   = 16,
    parameter int MIN_COUNT   = 16
) (
    input  logic           clock,
    input  logic           reset,
    uart_autobaud_if.slave bus
);

    // Span of 8 bit times needs 3 more bits than one interval.
    localparam int TOT_W = CNT_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HIGH = 3'd1,
        WAIT_FALL = 3'd2,
        MEASURE   = 3'd3,
        CHECK     = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q, fall_q;
    logic [TOT_W-1:0]     total_q, total_d;
    logic [CNT_WIDTH-1:0] interval_q, interval_d;
    logic [CNT_WIDTH-1:0] ref_q, ref_d;
    logic [CNT_WIDTH-1:0] bit_period_q, bit_period_d;
    logic [2:0]           edge_cnt_q, edge_cnt_d;

    logic [CNT_WIDTH-1:0] int_cur;
    logic [CNT_WIDTH-1:0] diff;
    logic                 in_tol;
    logic [2:0]           edge_num;
    logic [TOT_W-1:0]     p;
    logic                 p_ok;
    logic                 busy, done, error;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            fall_q       <= 1'b0;
            total_q      <= '0;
            interval_q   <= '0;
            ref_q        <= '0;
            bit_period_q <= '0;
            edge_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= bus.rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            // Registered edge flag: same 3-clock latency for every edge,
            // so it cancels out of all intervals.
            fall_q       <= rx_prev_q & ~rx_sync_q;
            total_q      <= total_d;
            interval_q   <= interval_d;
            ref_q        <= ref_d;
            bit_period_q <= bit_period_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        interval_d   = interval_q;
        ref_d        = ref_q;
        bit_period_d = bit_period_q;
        edge_cnt_d   = edge_cnt_q;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        // Interval including the current cycle, i.e. distance from the
        // previous falling edge when fall_q is high now.
        int_cur  = interval_q + CNT_WIDTH'(1);
        edge_num = edge_cnt_q + 3'd1;
        diff     = (int_cur >= ref_q) ? (int_cur - ref_q) : (ref_q - int_cur);
        in_tol   = (diff <= (ref_q >> 2));
        // Eight bit times divided by eight, rounded to nearest.
        p        = (total_q + TOT_W'(4)) >> 3;
        p_ok     = (p >= TOT_W'(MIN_COUNT));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                busy = 1'b1;
                // Never arm in the middle of a character.
                if (rx_sync_q) begin
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                busy = 1'b1;
                if (fall_q) begin
                    total_d    = '0;
                    interval_d = '0;
                    edge_cnt_d = 3'd1;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                busy       = 1'b1;
                total_d    = total_q + TOT_W'(1);
                interval_d = int_cur;
                if (interval_q == '1) begin
                    // Stuck line or a rate too slow to count.
                    state_d = FAIL;
                end else if (fall_q) begin
                    interval_d = '0;
                    edge_cnt_d = edge_num;
                    if (edge_num == 3'd2) begin
                        ref_d = int_cur;
                    end else if (!in_tol) begin
                        state_d = FAIL;
                    end else if (edge_num == 3'd5) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (p_ok) begin
                    done         = 1'b1;
                    bit_period_d = p[CNT_WIDTH-1:0];
                end else begin
                    error = 1'b1;
                end
                state_d = IDLE;
            end
            FAIL: begin
                error   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The new period is driven straight out in the done cycle.
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.error       = error;
    assign bus.bit_period  = bit_period_d;
    assign bus.half_period = bit_period_d >> 1;
    assign bus.state_dbg   = state_q;

    a_done_error_excl: assert property (@(posedge clock) disable iff (reset)
        !(done && error));

    // A bit can never be longer than one second of clocks.
    a_period_range: assert property (@(posedge clock) disable iff (reset)
        done |-> (32'(bit_period_d) <= $unsigned(CLOCK_INPUT)));

endmodule

// File: tb/tb_uart_autobaud.sv
`timescale 1ns/1ps

module tb_uart_autobaud;

    localparam int W   = 16;
    localparam int W_S = 10;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_autobaud_if #(.CNT_WIDTH(W))   bus ();
    uart_autobaud_if #(.CNT_WIDTH(W_S)) bus_s ();

    uart_autobaud #(.CLOCK_INPUT(50_000_000), .CNT_WIDTH(W), .MIN_COUNT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow counter copy so the interval timeout is reachable quickly.
    uart_autobaud #(.CLOCK_INPUT(50_000_000), .CNT_WIDTH(W_S), .MIN_COUNT(16)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_bp;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done_cyc = 0, err_cyc = 0;
    logic err_busy = 1'b0;
    int err_s_cnt = 0, err_s_cyc = 0, done_s_cnt = 0;
    int fall_cyc[5];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_done: got bit_period %0d required no done", bus.bit_period);
            end else begin
                exp_bp = exp_q.pop_front();
                check("sb_bit_period", bus.bit_period, exp_bp);
                check("sb_half_period", bus.half_period, exp_bp >> 1);
            end
        end
        if (bus.error) begin
            err_cnt++;
            err_cyc  = cyc;
            err_busy = bus.busy;
        end
        if (bus.done && bus.error) both_cnt++;
        if (bus_s.error) begin
            err_s_cnt++;
            err_s_cyc = cyc;
        end
        if (bus_s.done) done_s_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("arm_busy", bus.busy, 1);
        repeat (2) tick();
        check("arm_state_wait_fall", bus.state_dbg, 2);
    endtask

    // Drives n falling edges; edge k (k>=1) comes iv[k-1] cycles after the
    // previous one, with rx low for `low` cycles after each edge.
    task automatic send_frame(input int n, input int i2, input int i3,
                              input int i4, input int i5, input int low);
        int iv[4];
        iv = '{i2, i3, i4, i5};
        bus.rx = 1'b0;
        fall_cyc[0] = cyc;
        for (int k = 1; k < n; k++) begin
            repeat (low) tick();
            bus.rx = 1'b1;
            repeat (iv[k-1] - low) tick();
            bus.rx = 1'b0;
            fall_cyc[k] = cyc;
        end
    endtask

    task automatic tail(input int low);
        repeat (low) tick();
        bus.rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((bus.busy || bus.state_dbg != 3'd0) && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle_busy", bus.busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int i2, i3, i4, i5;   // edge-to-edge intervals
        int low;              // rx low time after each edge
        int exp_done;
        int exp_err;
        int edge_idx;         // fall index that triggers the outcome
        int bp;
        int hp;
    } vec_t;

    vec_t vecs[9];

    int d0, e0, t0;

    initial begin
        vecs[0] = '{868, 868, 868, 868, 434, 1, 0, 4, 434, 217};
        vecs[1] = '{10416, 10416, 10416, 10416, 5208, 1, 0, 4, 5208, 2604};
        vecs[2] = '{16, 16, 16, 16, 8, 0, 1, 4, 5208, 2604};
        vecs[3] = '{103, 103, 103, 103, 51, 1, 0, 4, 52, 26};      // 412/8 = 51.5 -> 52
        vecs[4] = '{34, 34, 34, 34, 17, 1, 0, 4, 17, 8};           // smallest legal period region
        vecs[5] = '{30, 30, 30, 30, 15, 0, 1, 4, 17, 8};           // 15 < 16 rejected
        vecs[6] = '{868, 1085, 651, 868, 434, 1, 0, 4, 434, 217};  // diffs exactly ref/4
        vecs[7] = '{868, 868, 868, 1086, 434, 0, 1, 4, 434, 217};  // one past tolerance
        vecs[8] = '{868, 868, 1300, 868, 434, 0, 1, 3, 434, 217};  // bad 4th edge

        bus.start   = 1'b0;
        bus.rx      = 1'b1;
        bus_s.start = 1'b0;
        bus_s.rx    = 1'b1;

        // Reset state.
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_bit_period", bus.bit_period, 0);
        check("rst_half_period", bus.half_period, 0);
        check("rst_state", bus.state_dbg, 0);
        reset = 1'b0;
        repeat (2) tick();

        for (int v = 0; v < 9; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            arm();
            if (vecs[v].exp_done != 0) exp_q.push_back(W'(vecs[v].bp));
            send_frame(5, vecs[v].i2, vecs[v].i3, vecs[v].i4, vecs[v].i5, vecs[v].low);
            tail(vecs[v].low);
            wait_idle(64);
            check($sformatf("v%0d_done_count", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_error_count", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_bit_period", v), bus.bit_period, vecs[v].bp);
            check($sformatf("v%0d_half_period", v), bus.half_period, vecs[v].hp);
            if (vecs[v].exp_done != 0) begin
                check($sformatf("v%0d_done_cycle", v), done_cyc, fall_cyc[vecs[v].edge_idx] + 4);
            end else begin
                check($sformatf("v%0d_error_cycle", v), err_cyc, fall_cyc[vecs[v].edge_idx] + 4);
                check($sformatf("v%0d_busy_at_error", v), err_busy, 0);
            end
        end

        // Reset in the middle of a measurement, after the third edge.
        arm();
        send_frame(3, 868, 868, 0, 0, 434);
        repeat (6) tick();
        check("midrst_state_measure", bus.state_dbg, 3);
        reset  = 1'b1;
        bus.rx = 1'b1;
        tick();
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_error", bus.error, 0);
        check("midrst_bit_period", bus.bit_period, 0);
        check("midrst_half_period", bus.half_period, 0);
        check("midrst_state", bus.state_dbg, 0);
        reset = 1'b0;
        repeat (4) tick();
        d0 = done_cnt;
        arm();
        exp_q.push_back(W'(434));
        send_frame(5, 868, 868, 868, 868, 434);
        tail(434);
        wait_idle(64);
        check("postrst_done_count", done_cnt - d0, 1);
        check("postrst_bit_period", bus.bit_period, 434);
        check("postrst_half_period", bus.half_period, 217);

        // start pulsed again while busy is ignored.
        d0 = done_cnt;
        arm();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_q.push_back(W'(434));
        send_frame(5, 868, 868, 868, 868, 434);
        tail(434);
        wait_idle(64);
        repeat (10) tick();
        check("busy_start_done_count", done_cnt - d0, 1);
        check("busy_start_state_idle", bus.state_dbg, 0);

        // Interval timeout on the narrow copy: rx held low after edge 1.
        bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        repeat (3) tick();
        bus_s.rx = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 1100 && err_s_cnt == 0; k++) tick();
        check("timeout_error_count", err_s_cnt, 1);
        check("timeout_error_cycle", err_s_cyc, t0 + (1 << W_S) + 4);
        check("timeout_no_done", done_s_cnt, 0);
        bus_s.rx = 1'b1;
        repeat (4) tick();

        check("done_error_overlap", both_cnt, 0);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate detector for the UART block. When armed, it watches the asynchronous rx line for a 0x55 sync character, times it with the system clock, and reports the measured bit period in clock cycles. The UART receiver and transmitter load that period into their bit counters, so one bitstream-independent build serves any host baud rate. It performs the inverse of the fixed reference-clock divider: it recovers an unknown rate instead of generating a known one.

## Interface
- CLOCK_INPUT, 50_000_000, system clock frequency in Hz (documentation/assertions only)
- CNT_WIDTH, 16, width of `bit_period` and of the per-interval counter
- MIN_COUNT, 16, smallest legal bit period in cycles; shorter measurements flag `error`

- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  arm request, sampled only in IDLE
- rx  in  1  asynchronous serial line, idle high
- busy  out  1  high from accepted `start` until `done` or `error`
- done  out  1  one-cycle pulse; `bit_period`/`half_period` updated the same cycle
- error  out  1  one-cycle pulse; measurement rejected
- bit_period  out  CNT_WIDTH  measured cycles per bit
- half_period  out  CNT_WIDTH  `bit_period >> 1`, for mid-bit sampling

## Operation
- rx passes through a 2-FF synchronizer (reset value 1), then a falling-edge detector on the synchronized signal (`fall` = prev 1 and now 0).
- 0x55 sent LSB-first gives start = 0, data = 1,0,1,0,1,0,1,0, stop = 1. That is five falling edges, at the start bit and at d1, d3, d5, d7. Each is 2 bit times after the previous one, so the first-to-fifth span is 8 bit times.
- FSM states:
  - IDLE: `busy` = 0. On `start` go to WAIT_HIGH; `busy` = 1.
  - WAIT_HIGH: wait for synchronized rx = 1 so the block never arms mid-character. Then go to WAIT_FALL.
  - WAIT_FALL: on `fall`, clear the total counter and the interval counter, set `edge_cnt` = 1, and go to MEASURE.
  - MEASURE: total and interval counters increment every cycle. On each `fall`:
    - Edge 2: store the interval as `ref_int`.
    - Edges 3-5: the interval must satisfy |interval − ref_int| ≤ `ref_int >> 2`, otherwise go to FAIL.
    - All edges: clear the interval counter and increment `edge_cnt`.
    - On edge 5, go to CHECK.
  - CHECK: compute `p = (total + 4) >> 3`, rounded. If p < MIN_COUNT go to FAIL; else go to IDLE with `done` = 1, `bit_period` = p, `half_period` = p >> 1.
  - FAIL: `error` = 1 for one cycle, then IDLE. `bit_period` and `half_period` keep their previous values.
- Total counter is CNT_WIDTH+3 bits. Timeout: if the interval counter reaches all-ones in MEASURE, go to FAIL. This catches a stuck line or a too-slow rate.
- `total` counts cycles from the cycle after edge 1 through the cycle of edge 5, inclusive. It equals the edge-to-edge distance in cycles.
- `start` is ignored while `busy` = 1.

## Timing
- Reset values: `busy` = 0, `done` = 0, `error` = 0, `bit_period` = 0, `half_period` = 0, FSM = IDLE, synchronizer = 1.
- `start` is sampled at edge N; `busy` = 1 from edge N+1.
- rx-to-`fall` latency is 3 clocks: 2 synchronizer stages plus the edge register. This latency is identical for every edge, so it cancels out of all measured intervals.
- `done` or `error` is asserted exactly 1 cycle after the 5th `fall` (the CHECK cycle). On an interval mismatch, `error` is asserted 1 cycle after the offending `fall`. `busy` deasserts in the same cycle that `done` or `error` is high.
- `done` and `error` are never high together.
- A synchronous `reset` in any state returns all outputs to their reset values at the next edge, including mid-measurement.

## Test plan
- Drive 0x55 with 434 cycles/bit (115200 baud at 50 MHz) after `start` -> `done` pulses once, `bit_period` = 434, `half_period` = 217, `error` = 0.
- Drive 0x55 with 5208 cycles/bit (9600 baud) -> `bit_period` = 5208, `half_period` = 2604.
- Drive 0x55 with 8 cycles/bit -> intervals consistent, p = 8 < 16 -> `error` pulse, `bit_period` keeps its prior value of 5208.
- Falling-edge intervals 868, 868, 1300, 868 -> `error` one cycle after the 4th `fall`, `busy` = 0, no `done`.
- Reset mid-MEASURE after edge 3 -> next cycle all outputs 0, FSM in IDLE. A new `start` plus 0x55 at 434 cycles/bit -> `bit_period` = 434.
- `start` pulsed while busy is ignored (exactly one `done`). Holding rx low for 2^16 cycles after edge 1 -> `error` timeout.
